// File: rtl/board_test_sequencer.sv
// Board self-test scheduler: runs enabled testers in slot order and records pass/fail/timeout masks.
// Latency: progress/result seen 2 cycles late through synchronizers; done pulses 1 cycle after the last slot.
// No backpressure: testers are supervised by timeouts, and abort ends a run on the next edge.
module board_test_sequencer #(
    parameter int NTESTS    = 4,
    parameter int INIT_LEN  = 4,
    parameter int START_TMO = 1024,
    parameter int RUN_TMO   = 2**24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NTESTS-1:0] test_enable,
    input  logic [NTESTS-1:0] test_progress,
    input  logic [NTESTS-1:0] test_result,
    output logic [NTESTS-1:0] test_init,
    output logic              busy,
    output logic              done,
    output logic [1:0]        current_test,
    output logic [NTESTS-1:0] pass_mask,
    output logic [NTESTS-1:0] fail_mask,
    output logic [NTESTS-1:0] tmo_mask,
    output logic              aborted
);
    localparam int MAX_TMO = (START_TMO > RUN_TMO) ? START_TMO : RUN_TMO;
    localparam int CW      = (MAX_TMO > 2) ? $clog2(MAX_TMO) : 1;
    localparam int IW      = $clog2(NTESTS + 1);

    localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_LEN - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_TMO - 1);
    localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_TMO - 1);
    localparam logic [IW-1:0] IDX_END    = IW'(NTESTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_END,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [NTESTS-1:0] en_q, en_d;
    logic [NTESTS-1:0] pass_q, pass_d;
    logic [NTESTS-1:0] fail_q, fail_d;
    logic [NTESTS-1:0] tmo_q, tmo_d;
    logic              aborted_q, aborted_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;

    logic [NTESTS-1:0] prog_meta_q, prog_sync_q;
    logic [NTESTS-1:0] res_meta_q, res_sync_q;

    logic [NTESTS-1:0] sel_oh;
    logic              start_rise;
    logic              en_bit;
    logic              prog_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_meta_q <= '0;
            prog_sync_q <= '0;
            res_meta_q  <= '0;
            res_sync_q  <= '0;
        end else begin
            prog_meta_q <= test_progress;
            prog_sync_q <= prog_meta_q;
            res_meta_q  <= test_result;
            res_sync_q  <= res_meta_q;
        end
    end

    // Zero once idx walks past the last slot, so no init or mask bit can be hit.
    assign sel_oh     = NTESTS'(1) << idx_q;
    assign start_rise = start & ~start_q;
    assign en_bit     = |(en_q & sel_oh);
    assign prog_bit   = |(prog_sync_q & sel_oh);
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_inc;
        en_d      = en_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        tmo_d     = tmo_q;
        aborted_d = aborted_q;
        busy_d    = busy_q;
        start_d   = start;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_rise) begin
                    en_d      = test_enable;
                    pass_d    = '0;
                    fail_d    = '0;
                    tmo_d     = '0;
                    aborted_d = 1'b0;
                    busy_d    = 1'b1;
                    idx_d     = '0;
                    state_d   = S_SELECT;
                end
            end
            S_SELECT: begin
                cnt_d = '0;
                if (idx_q == IDX_END) begin
                    state_d = S_DONE;
                end else if (!en_bit) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (cnt_q == INIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (prog_bit) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_END;
                end else if (cnt_q == START_LAST) begin
                    tmo_d   = tmo_q | sel_oh;
                    state_d = S_NEXT;
                end
            end
            S_WAIT_END: begin
                if (!prog_bit) begin
                    pass_d  = pass_q | (sel_oh & res_sync_q);
                    fail_d  = fail_q | (sel_oh & ~res_sync_q);
                    state_d = S_NEXT;
                end else if (cnt_q == RUN_LAST) begin
                    tmo_d   = tmo_q | sel_oh;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                cnt_d   = '0;
                idx_d   = idx_q + 1'b1;
                state_d = S_SELECT;
            end
            S_DONE: begin
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over any completion or timeout decided above on this edge.
        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
            idx_d     = idx_q;
            cnt_d     = '0;
            pass_d    = pass_q;
            fail_d    = fail_q;
            tmo_d     = tmo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            en_q      <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            tmo_q     <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            tmo_q     <= tmo_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
        end
    end

    // Decoded straight from flops so an async reset drops init immediately.
    assign test_init    = (state_q == S_LAUNCH) ? sel_oh : '0;
    assign done         = (state_q == S_DONE);
    assign busy         = busy_q;
    assign current_test = 2'(idx_q);
    assign pass_mask    = pass_q;
    assign fail_mask    = fail_q;
    assign tmo_mask     = tmo_q;
    assign aborted      = aborted_q;
endmodule
